pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Hazard and control-select sequencer for the 5-stage pipelined MIPS core.
- Drives the select lines of the datapath's 32-bit 2:1/3:1 muxes: PC source, ALU operand forwarding, and the ID/EX control-bubble mux.
- Drives PC/IF-ID write enables and the IF/ID flush.
- Multi-cycle stalls are sequenced by an internal FSM with a countdown, so a hazard is not re-decided mid-stall.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 32, width of statistics counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  REG_AW  rs of instruction in ID
- id_rt  in  REG_AW  rt of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- id_branch  in  1  ID holds beq/bne (compare resolved in ID)
- id_branch_taken  in  1  ID branch comparator result
- id_jump  in  1  ID holds j/jal
- ex_rs  in  REG_AW  rs in EX
- ex_rt  in  REG_AW  rt in EX
- ex_dst  in  REG_AW  destination in EX, after RegDst mux
- ex_reg_write  in  1  EX writes register
- ex_mem_read  in  1  EX is load
- mem_dst  in  REG_AW  destination in MEM
- mem_reg_write  in  1  MEM writes register
- mem_mem_read  in  1  MEM is load
- wb_dst  in  REG_AW  destination in WB
- wb_reg_write  in  1  WB writes register
- ext_stall  in  1  external freeze request (memory wait)
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID enable
- ifid_flush  out  1  zero IF/ID on next edge
- idex_bubble  out  1  select zero-control input of ID/EX control mux
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target
- fwd_a  out  2  ALU A: 00 regfile, 10 EX/MEM, 01 MEM/WB
- fwd_b  out  2  ALU B: same encoding
- stall_cycles  out  CNT_W  hazard-stall cycle count
- flush_count  out  CNT_W  redirect count

Behaviour:
- Register $0 never matches any hazard or forward.
- Stall requirement N, evaluated in RUN, first match wins:
  - ex_mem_read and ex_dst matches id_branch operand: N=2.
  - ex_reg_write and ex_dst matches id_branch operand: N=1.
  - mem_mem_read and mem_dst matches id_branch operand: N=1.
  - ex_mem_read and ex_dst matches id_rs, or matches id_rt when id_uses_rt: N=1.
  - Otherwise N=0.
  - "Branch operand" means id_rs or id_rt, both used when id_branch.
- FSM states RUN and STALL, with a registered remaining-count rem (2 bits).
- RUN, N>0: this cycle pc_write=0, ifid_write=0, idex_bubble=1. If N=2, go to STALL with rem=1; else stay in RUN.
- STALL: same stall outputs. rem decrements; go to RUN when rem reaches 0. Hazards are not evaluated.
- Redirect, only in RUN with N=0 and no ext_stall:
  - id_jump: pc_src=10, ifid_flush=1.
  - Else id_branch and id_branch_taken: pc_src=01, ifid_flush=1.
  - Jump wins if both are asserted.
- A branch seen during a stall is ignored; it is re-evaluated once the stall clears (instruction still in ID).
- ext_stall has highest priority:
  - pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=0, pc_src=00.
  - FSM state and rem hold; counters hold.
- Idle outputs: pc_write=1, ifid_write=1, others 0.
- Forwarding is combinational and always active, including during stalls:
  - fwd_a=10 if mem_reg_write and mem_dst==ex_rs.
  - Else 01 if wb_reg_write and wb_dst==ex_rs.
  - Else 00.
  - EX/MEM has priority over MEM/WB. fwd_b is the same rule using ex_rt.
- Reset (rst_n low, asynchronous):
  - State RUN, rem=0, counters 0.
  - Outputs forced: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, pc_src=00, fwd_a=fwd_b=00.
  - Reset asserted mid-STALL aborts the stall. After release, start in RUN.
- Latency: all control outputs are Mealy, valid in the same cycle as inputs; state updates on the rising edge.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: stall_cycles increments each cycle a hazard stall is asserted, excluding ext_stall. flush_count increments each cycle ifid_flush=1. Both wrap modulo 2^CNT_W and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops exist. Ports remain present.

Test Plan:
- Load-use: ex_mem_read=1, ex_dst=8, id_rs=8 -> one cycle pc_write=0, idex_bubble=1. Next cycle (EX now clear) idle outputs; stall_cycles=1.
- Branch after load: ex_mem_read=1, ex_dst=9, id_branch=1, id_rt=9 held -> exactly 2 stall cycles (RUN->STALL->RUN). Then id_branch_taken=1 gives pc_src=01, ifid_flush=1.
- Forward priority: mem_dst=wb_dst=ex_rs=4, both write -> fwd_a=10. Set mem_reg_write=0 -> fwd_a=01. Set ex_rs=0 -> fwd_a=00.
- Jump and branch together: id_jump=1, id_branch_taken=1, no hazard -> pc_src=10, flush_count +1.
- ext_stall during STALL (rem=1): hold 3 cycles -> state holds, pc_write=0, idex_bubble=0. After release, one more stall cycle, then RUN.
- Reset mid-STALL: drop rst_n asynchronously -> outputs immediately take reset values. After release, RUN with no residual stall and counters 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/control-select sequencer for the 5-stage MIPS pipeline: stalls, redirects, forwarding selects.
// Optional statistics counters are enabled by defining HAZARD_STATS_EN.
module pipeline_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              id_branch,
  input  logic              id_branch_taken,
  input  logic              id_jump,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic              wb_reg_write,
  input  logic              ext_stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        pc_src,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  typedef enum logic {RUN, STALL} state_t;

  state_t     state, state_next;
  logic [1:0] rem, rem_next;
  logic       ex_br_hit, mem_br_hit, ex_use_hit;
  logic [1:0] need;

  // $0 is hardwired to zero, so it never creates a dependence
  function automatic logic reg_hit(input logic [REG_AW-1:0] dst, input logic [REG_AW-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

  always_comb begin
    ex_br_hit  = id_branch && (reg_hit(ex_dst, id_rs) || reg_hit(ex_dst, id_rt));
    mem_br_hit = id_branch && (reg_hit(mem_dst, id_rs) || reg_hit(mem_dst, id_rt));
    ex_use_hit = reg_hit(ex_dst, id_rs) || (id_uses_rt && reg_hit(ex_dst, id_rt));
    need = 2'd0;
    if (ex_mem_read && ex_br_hit)       need = 2'd2;
    else if (ex_reg_write && ex_br_hit) need = 2'd1;
    else if (mem_mem_read && mem_br_hit) need = 2'd1;
    else if (ex_mem_read && ex_use_hit) need = 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      rem   <= 2'd0;
    end else begin
      state <= state_next;
      rem   <= rem_next;
    end
  end

  // ext_stall freezes everything; a running stall countdown is never re-decided
  always_comb begin
    state_next  = state;
    rem_next    = rem;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pc_src      = 2'b00;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (ext_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (state == STALL) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      if (rem <= 2'd1) begin
        rem_next   = 2'd0;
        state_next = RUN;
      end else begin
        rem_next = rem - 2'd1;
      end
    end else if (need != 2'd0) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      if (need == 2'd2) begin
        state_next = STALL;
        rem_next   = 2'd1;
      end
    end else if (id_jump) begin
      pc_src     = 2'b10;
      ifid_flush = 1'b1;
    end else if (id_branch && id_branch_taken) begin
      pc_src     = 2'b01;
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rst_n) begin
      if (mem_reg_write && reg_hit(mem_dst, ex_rs))     fwd_a = 2'b10;
      else if (wb_reg_write && reg_hit(wb_dst, ex_rs))  fwd_a = 2'b01;
      if (mem_reg_write && reg_hit(mem_dst, ex_rt))     fwd_b = 2'b10;
      else if (wb_reg_write && reg_hit(wb_dst, ex_rt))  fwd_b = 2'b01;
    end
  end

`ifdef HAZARD_STATS_EN
  // Outside reset idex_bubble is only ever raised by a hazard stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (idex_bubble) stall_cycles <= stall_cycles + CNT_W'(1);
      if (ifid_flush)  flush_count  <= flush_count + CNT_W'(1);
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
